// File: rtl/lime_io_pkg.sv
// lime_io_pkg: shared definitions for the lime output serial transmitter.
// Optional feature macro: LIME_TX_PARITY_EN (even-parity bit after the data bits).
package lime_io_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;
    localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/lime_output_tx_if.sv
// lime_output_tx_if: processor-side write port of the output transmitter.
// master = processor store path, slave = transmitter.
interface lime_output_tx_if #(
    parameter int unsigned FIFO_DEPTH = 4
) ();

    logic [15:0]                   out_word;
    logic                          out_we;
    logic                          fifo_full;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;

    modport master (
        output out_word,
        output out_we,
        input  fifo_full,
        input  fifo_count,
        input  overflow
    );

    modport slave (
        input  out_word,
        input  out_we,
        output fifo_full,
        output fifo_count,
        output overflow
    );

endinterface

// File: rtl/lime_tx_fifo.sv
// lime_tx_fifo: synchronous word FIFO with wrap-around pointers and an occupancy count.
// Pushes while full and pops while empty are ignored.
module lime_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lime_output_tx.sv
// lime_output_tx: buffers 16-bit output words and sends each as two UART frames,
// low byte first, with zero gap between back-to-back frames.
// Optional feature macro: LIME_TX_PARITY_EN adds an even-parity bit after DATA.
module lime_output_tx
    import lime_io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic              CLK,
    input  logic              reset_n,
    lime_output_tx_if.slave   out_if,
    output logic              tx,
    output logic              tx_busy
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);

    tx_state_e                   r_state;
    logic [TW-1:0]               r_timer;
    logic [2:0]                  r_bit_idx;
    logic [7:0]                  r_shift;
    logic [7:0]                  r_word_hi;
    logic                        r_byte_sel;
    logic                        r_tx;
    logic                        r_overflow;
    logic                        w_bit_end;
    logic                        w_pop;
    logic [15:0]                 w_dout;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    lime_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .CLK     (CLK),
        .reset_n (reset_n),
        .push    (out_if.out_we),
        .pop     (w_pop),
        .din     (out_if.out_word),
        .dout    (w_dout),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign w_bit_end         = (r_timer == TW'(CLKS_PER_BIT - 1));
    // A pop happens leaving IDLE or at the end of a high-byte STOP; both load a new word.
    assign w_pop             = !w_empty &&
                               ((r_state == S_IDLE) ||
                                (r_state == S_STOP && w_bit_end && r_byte_sel));
    assign tx                = r_tx;
    assign tx_busy           = (r_state != S_IDLE);
    assign out_if.fifo_full  = w_full;
    assign out_if.fifo_count = w_count;
    assign out_if.overflow   = r_overflow;

`ifdef LIME_TX_PARITY_EN
    logic r_parity;

    // Running XOR of data bits already sent in the current byte.
    always_ff @(posedge CLK) begin
        if (!reset_n || r_state == S_START) begin
            r_parity <= 1'b0;
        end else if (r_state == S_DATA && w_bit_end) begin
            r_parity <= r_parity ^ r_shift[0];
        end
    end
`endif

    // Serializer FSM: bit timer, shift register, byte select and line driver.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_word_hi  <= '0;
            r_byte_sel <= 1'b0;
            r_tx       <= STOP_BIT;
        end else begin
            if (w_pop) begin
                r_state    <= S_START;
                r_tx       <= START_BIT;
                r_timer    <= '0;
                r_shift    <= w_dout[7:0];
                r_word_hi  <= w_dout[15:8];
                r_byte_sel <= 1'b0;
            end else if (r_state != S_IDLE) begin
                r_timer <= w_bit_end ? '0 : r_timer + 1'b1;
                if (w_bit_end) begin
                    case (r_state)
                        S_START: begin
                            r_state   <= S_DATA;
                            r_tx      <= r_shift[0];
                            r_bit_idx <= '0;
                        end
                        S_DATA: begin
                            if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef LIME_TX_PARITY_EN
                                r_state <= S_PARITY;
                                r_tx    <= r_parity ^ r_shift[0];
`else
                                r_state <= S_STOP;
                                r_tx    <= STOP_BIT;
`endif
                            end else begin
                                r_bit_idx <= r_bit_idx + 1'b1;
                                r_shift   <= r_shift >> 1;
                                r_tx      <= r_shift[1];
                            end
                        end
                        S_PARITY: begin
                            r_state <= S_STOP;
                            r_tx    <= STOP_BIT;
                        end
                        S_STOP: begin
                            if (!r_byte_sel) begin
                                r_byte_sel <= 1'b1;
                                r_shift    <= r_word_hi;
                                r_state    <= S_START;
                                r_tx       <= START_BIT;
                            end else begin
                                r_state <= S_IDLE;
                                r_tx    <= STOP_BIT;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_tx    <= STOP_BIT;
                        end
                    endcase
                end
            end
        end
    end

    // Sticky flag for writes dropped because the FIFO was full.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (out_if.out_we && w_full) begin
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lime_output_tx.sv
// tb_lime_output_tx: self-checking bench for lime_output_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Optional feature macro: LIME_TX_PARITY_EN (bench expects parity frames when defined).
module tb_lime_output_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef LIME_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int WORD_CYCLES = 2 * FRAME_BITS * CPB;

    int   total = 0;
    int   bad   = 0;
    logic clk   = 1'b0;
    logic rst_n;
    logic tx;
    logic tx_busy;
    logic g_ovf = 1'b0;
    logic [15:0] g_words[$];

    lime_output_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    lime_output_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK     (clk),
        .reset_n (rst_n),
        .out_if  (bus),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.out_we   = 1'b0;
        bus.out_word = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        g_ovf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", tx_busy); end
        total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.fifo_count); end
        total++; if (bus.fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", bus.fifo_full); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.overflow); end
    endtask

    // Writes g_words[0..n-1] on consecutive edges into an idle, empty DUT and checks
    // FIFO status after each write plus the exact line waveform of the accepted words.
    task automatic run_stream(input int n, input string tag);
        logic        acc[8];
        int          exp_cnt[8];
        logic        exp_ovf[8];
        int          c = 0;
        logic        o = g_ovf;
        logic        bits[$];
        logic [7:0]  bv;
        for (int i = 0; i < n; i++) begin
            acc[i] = (c < DEPTH);
            if (!acc[i]) o = 1'b1;
            c = c + (acc[i] ? 1 : 0) - ((i == 1) ? 1 : 0);
            exp_cnt[i] = c;
            exp_ovf[i] = o;
        end
        for (int i = 0; i < n; i++) begin
            if (acc[i]) begin
                for (int b = 0; b < 2; b++) begin
                    bv = g_words[i][b*8 +: 8];
                    repeat (CPB) bits.push_back(1'b0);
                    for (int k = 0; k < 8; k++) repeat (CPB) bits.push_back(bv[k]);
`ifdef LIME_TX_PARITY_EN
                    repeat (CPB) bits.push_back(^bv);
`endif
                    repeat (CPB) bits.push_back(1'b1);
                end
            end
        end
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    bus.out_we   = 1'b1;
                    bus.out_word = g_words[i];
                    @(negedge clk);
                    total++; if (bus.fifo_count !== 3'(exp_cnt[i])) begin bad++;
                        $display("FAIL %s count_w%0d got=%0d want=%0d", tag, i, bus.fifo_count, exp_cnt[i]); end
                    total++; if (bus.fifo_full !== (exp_cnt[i] == DEPTH)) begin bad++;
                        $display("FAIL %s full_w%0d got=%b want=%b", tag, i, bus.fifo_full, exp_cnt[i] == DEPTH); end
                    total++; if (bus.overflow !== exp_ovf[i]) begin bad++;
                        $display("FAIL %s ovf_w%0d got=%b want=%b", tag, i, bus.overflow, exp_ovf[i]); end
                end
                bus.out_we = 1'b0;
            end
            begin
                @(posedge clk);
                @(negedge clk);
                total++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin bad++;
                    $display("FAIL %s pre_pop got tx=%b busy=%b want tx=1 busy=0", tag, tx, tx_busy); end
                for (int j = 0; j < bits.size(); j++) begin
                    @(negedge clk);
                    total++; if (tx !== bits[j] || tx_busy !== 1'b1) begin bad++;
                        $display("FAIL %s cycle%0d got tx=%b busy=%b want tx=%b busy=1", tag, j, tx, tx_busy, bits[j]); end
                end
                @(negedge clk);
                total++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin bad++;
                    $display("FAIL %s end_idle got tx=%b busy=%b want tx=1 busy=0", tag, tx, tx_busy); end
            end
        join
        g_ovf = o;
    endtask

    task automatic test_single();
        g_words = '{16'h1234};
        run_stream(1, "single");
        total++; if (WORD_CYCLES != 2 * FRAME_BITS * CPB || tx_busy !== 1'b0) begin bad++;
            $display("FAIL single_done got busy=%b want 0", tx_busy); end
    endtask

    task automatic test_back_to_back();
        g_words = '{16'hFFFF, 16'h0000};
        run_stream(2, "b2b");
    endtask

    task automatic test_overflow();
        g_words = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
        run_stream(6, "ovf");
        total++; if (bus.overflow !== 1'b1) begin bad++;
            $display("FAIL ovf_sticky got=%b want=1", bus.overflow); end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        bus.out_we   = 1'b1;
        bus.out_word = 16'h1234;
        @(negedge clk);
        bus.out_word = 16'h5678;
        @(negedge clk);
        bus.out_we   = 1'b0;
        repeat (7) @(negedge clk);
        total++; if (tx_busy !== 1'b1 || bus.fifo_count !== 3'd1) begin bad++;
            $display("FAIL mid_pre got busy=%b count=%0d want busy=1 count=1", tx_busy, bus.fifo_count); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_tx got=%b want=1", tx); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", tx_busy); end
        total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", bus.fifo_count); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL mid_ovf got=%b want=0", bus.overflow); end
        rst_n = 1'b1;
        g_ovf = 1'b0;
        g_words = '{16'hA5A5};
        run_stream(1, "after_rst");
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            g_words.delete();
            for (int i = 0; i < n; i++) g_words.push_back(16'($urandom));
            run_stream(n, $sformatf("rand%0d", r));
        end
    endtask

`ifdef LIME_TX_PARITY_EN
    task automatic test_parity();
        g_words = '{16'h0001};
        run_stream(1, "parity");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_random();
`ifdef LIME_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
